tlu_ccr_trapstack: RTL and testbench

- TLU-side owner of the per-thread condition-code trap stack (TSTATE.CCR).
- On a trap, reads the live per-thread CCR (exu_tlu_ccr0_w..exu_tlu_ccr3_w) and pushes it onto that thread's stack.
- On DONE/RETRY, pops the saved value and writes it back to the EXU through tlu_exu_ccr_m qualified by tlu_exu_cwpccr_update_m, entering the EXU M-stage CCR mux.
- Four threads; stack depth MAXTL per thread.

---
 rtl/tlu_ccr_pkg.sv | 20 ++
 rtl/tlu_ccr_thr_stack.sv | 80 ++++++++
 rtl/tlu_ccr_trapstack.sv | 117 +++++++++++
 tb/tb_tlu_ccr_trapstack.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tlu_ccr_pkg.sv
// Shared constants, types and helpers for the TLU CCR trap stack.
package tlu_ccr_pkg;

    localparam int unsigned MAXTL_DFLT = 6;
    localparam int unsigned TLW        = 3;
    localparam int unsigned NTHR       = 4;
    localparam int unsigned CCR_W      = 8;

    typedef logic [CCR_W-1:0] ccr_t;
    typedef logic [TLW-1:0]   tl_t;

    // One-hot thread select from a 2-bit thread id
    function automatic logic [NTHR-1:0] tid_dec(input logic [1:0] tid);
        logic [NTHR-1:0] sel;
        sel      = '0;
        sel[tid] = 1'b1;
        return sel;
    endfunction

endpackage

// File: rtl/tlu_ccr_thr_stack.sv
// Per-thread CCR trap stack: entries 1..MAXTL, trap-level counter and sticky
// overflow/underflow flags. Entry contents are not reset.
module tlu_ccr_thr_stack #(
    parameter int unsigned MAXTL = 6,
    parameter int unsigned TLW   = 3,
    parameter int unsigned EW    = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           push,
    input  logic           pop,
    input  logic [EW-1:0]  push_data,
    output logic [EW-1:0]  pop_data,
    output logic           pop_ok,
    output logic [TLW-1:0] tl,
    output logic           err_ovf,
    output logic           err_unf
);

    localparam logic [TLW-1:0] TL_MAX = TLW'(MAXTL);

    logic [MAXTL:1][EW-1:0] mem_q;
    logic [TLW-1:0]         tl_q, tl_d;
    logic [TLW-1:0]         wr_idx;
    logic                   ovf_q, ovf_d;
    logic                   unf_q, unf_d;
    logic                   full, empty;

    assign full   = (tl_q == TL_MAX);
    assign empty  = (tl_q == '0);
    // A full stack keeps overwriting its top entry
    assign wr_idx = full ? TL_MAX : tl_q + TLW'(1);
    // A push to this thread flushes a same-cycle pop
    assign pop_ok = pop & ~push & ~empty;

    // Next level and sticky error flags
    always_comb begin
        tl_d  = tl_q;
        ovf_d = ovf_q;
        unf_d = unf_q;
        if (push) begin
            if (full) ovf_d = 1'b1;
            else      tl_d  = tl_q + TLW'(1);
        end else if (pop) begin
            if (empty) unf_d = 1'b1;
            else       tl_d  = tl_q - TLW'(1);
        end
    end

    // Level counter and flags, cleared only by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tl_q  <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            tl_q  <= tl_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    // Entry storage, written on push
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_idx] <= push_data;
    end

    // Top-of-stack read for the pop path
    always_comb begin
        pop_data = '0;
        for (int i = 1; i <= int'(MAXTL); i++) begin
            if (tl_q == TLW'(i)) pop_data = mem_q[i];
        end
    end

    assign tl      = tl_q;
    assign err_ovf = ovf_q;
    assign err_unf = unf_q;

endmodule

// File: rtl/tlu_ccr_trapstack.sv
// TLU owner of the per-thread TSTATE.CCR trap stack. Traps push the live CCR,
// DONE/RETRY pops it back to the EXU one cycle later (E -> M).
// Optional: TLU_CCR_PARITY_EN adds an odd-parity bit per entry and err_par.
module tlu_ccr_trapstack
    import tlu_ccr_pkg::*;
#(
    parameter int unsigned MAXTL = MAXTL_DFLT,
    parameter int unsigned TLW   = tlu_ccr_pkg::TLW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CCR_W-1:0]  exu_tlu_ccr0_w,
    input  logic [CCR_W-1:0]  exu_tlu_ccr1_w,
    input  logic [CCR_W-1:0]  exu_tlu_ccr2_w,
    input  logic [CCR_W-1:0]  exu_tlu_ccr3_w,
    input  logic              trap_vld_g,
    input  logic [1:0]        trap_tid_g,
    input  logic              done_retry_vld_e,
    input  logic [1:0]        done_retry_tid_e,
    output logic              tlu_exu_cwpccr_update_m,
    output logic [CCR_W-1:0]  tlu_exu_ccr_m,
    output logic [4*TLW-1:0]  tl_thr,
    output logic [NTHR-1:0]   err_ovf,
    output logic [NTHR-1:0]   err_unf
`ifdef TLU_CCR_PARITY_EN
    ,
    output logic              err_par
`endif
);

`ifdef TLU_CCR_PARITY_EN
    localparam int unsigned EW = CCR_W + 1;
`else
    localparam int unsigned EW = CCR_W;
`endif

    logic [CCR_W-1:0] ccr_live [NTHR];
    logic [NTHR-1:0]  push_sel, pop_sel, pop_ok;
    logic [EW-1:0]    push_ent [NTHR];
    logic [EW-1:0]    pop_ent  [NTHR];
    logic [EW-1:0]    pop_mux;
    logic             pop_any;
    logic             upd_q;
    logic [CCR_W-1:0] ccr_q;

    assign ccr_live[0] = exu_tlu_ccr0_w;
    assign ccr_live[1] = exu_tlu_ccr1_w;
    assign ccr_live[2] = exu_tlu_ccr2_w;
    assign ccr_live[3] = exu_tlu_ccr3_w;

    // Same-thread trap flushes the DONE/RETRY: the pop never reaches the stack
    assign push_sel = tid_dec(trap_tid_g) & {NTHR{trap_vld_g}};
    assign pop_sel  = tid_dec(done_retry_tid_e) & {NTHR{done_retry_vld_e}} & ~push_sel;

    for (genvar g = 0; g < NTHR; g++) begin : g_thr
`ifdef TLU_CCR_PARITY_EN
        // Odd parity: the stored 9-bit word always has an odd number of ones
        assign push_ent[g] = {~^ccr_live[g], ccr_live[g]};
`else
        assign push_ent[g] = ccr_live[g];
`endif

        tlu_ccr_thr_stack #(
            .MAXTL (MAXTL),
            .TLW   (TLW),
            .EW    (EW)
        ) u_stack (
            .clk       (clk),
            .rst       (rst),
            .push      (push_sel[g]),
            .pop       (pop_sel[g]),
            .push_data (push_ent[g]),
            .pop_data  (pop_ent[g]),
            .pop_ok    (pop_ok[g]),
            .tl        (tl_thr[g*TLW +: TLW]),
            .err_ovf   (err_ovf[g]),
            .err_unf   (err_unf[g])
        );
    end

    // 4:1 pop-data mux; at most one thread pops per cycle
    always_comb begin
        pop_mux = '0;
        for (int t = 0; t < int'(NTHR); t++) begin
            if (pop_ok[t]) pop_mux = pop_ent[t];
        end
    end

    assign pop_any = |pop_ok;

    // M-stage restore strobe and data; data holds when no pop is accepted
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            upd_q <= 1'b0;
            ccr_q <= '0;
        end else begin
            upd_q <= pop_any;
            if (pop_any) ccr_q <= pop_mux[CCR_W-1:0];
        end
    end

`ifdef TLU_CCR_PARITY_EN
    logic par_q;

    // Parity error pulses alongside the strobe it belongs to
    always_ff @(posedge clk or posedge rst) begin
        if (rst) par_q <= 1'b0;
        else     par_q <= pop_any & ~(^pop_mux);
    end

    assign err_par = par_q;
`endif

    assign tlu_exu_cwpccr_update_m = upd_q;
    assign tlu_exu_ccr_m           = ccr_q;

endmodule

// File: tb/tb_tlu_ccr_trapstack.sv
// Directed self-checking bench for tlu_ccr_trapstack (MAXTL=6, TLW=3).
module tb_tlu_ccr_trapstack;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] ccr0, ccr1, ccr2, ccr3;
    logic       trap_vld;
    logic [1:0] trap_tid;
    logic       dr_vld;
    logic [1:0] dr_tid;
    logic       upd;
    logic [7:0] ccr_m;
    logic [11:0] tl_thr;
    logic [3:0] err_ovf, err_unf;
`ifdef TLU_CCR_PARITY_EN
    logic       err_par;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    tlu_ccr_trapstack dut (
        .clk                     (clk),
        .rst                     (rst),
        .exu_tlu_ccr0_w          (ccr0),
        .exu_tlu_ccr1_w          (ccr1),
        .exu_tlu_ccr2_w          (ccr2),
        .exu_tlu_ccr3_w          (ccr3),
        .trap_vld_g              (trap_vld),
        .trap_tid_g              (trap_tid),
        .done_retry_vld_e        (dr_vld),
        .done_retry_tid_e        (dr_tid),
        .tlu_exu_cwpccr_update_m (upd),
        .tlu_exu_ccr_m           (ccr_m),
        .tl_thr                  (tl_thr),
        .err_ovf                 (err_ovf),
        .err_unf                 (err_unf)
`ifdef TLU_CCR_PARITY_EN
        ,
        .err_par                 (err_par)
`endif
    );

    function automatic logic [2:0] tl_of(input int t);
        return tl_thr[t*3 +: 3];
    endfunction

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        trap_vld = 1'b0;
        dr_vld   = 1'b0;
    endtask

    task automatic trap(input logic [1:0] tid, input logic [7:0] v);
        case (tid)
            2'd0: ccr0 = v;
            2'd1: ccr1 = v;
            2'd2: ccr2 = v;
            default: ccr3 = v;
        endcase
        trap_vld = 1'b1;
        trap_tid = tid;
        cycle();
        trap_vld = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        trap_tid = 2'd0;
        dr_tid   = 2'd0;
        ccr0 = 8'h00; ccr1 = 8'h00; ccr2 = 8'h00; ccr3 = 8'h00;
        cycle();
        cycle();
        checks++;
        if (tl_thr !== 12'h000) begin
            failures++; $display("FAIL reset_tl got=%h exp=000", tl_thr);
        end
        checks++;
        if (upd !== 1'b0 || ccr_m !== 8'h00) begin
            failures++; $display("FAIL reset_out got=%b/%h exp=0/00", upd, ccr_m);
        end
        checks++;
        if (err_ovf !== 4'h0 || err_unf !== 4'h0) begin
            failures++; $display("FAIL reset_err got=%h/%h exp=0/0", err_ovf, err_unf);
        end
        rst = 1'b0;
        cycle();
    endtask

    task automatic test_basic();
        trap(2'd1, 8'hA5);
        checks++;
        if (tl_of(1) !== 3'd1 || upd !== 1'b0) begin
            failures++; $display("FAIL basic_push got=tl%0d upd%b exp=tl1 upd0", tl_of(1), upd);
        end
        dr_vld = 1'b1; dr_tid = 2'd1;
        cycle();
        dr_vld = 1'b0;
        checks++;
        if (upd !== 1'b1 || ccr_m !== 8'hA5 || tl_of(1) !== 3'd0) begin
            failures++;
            $display("FAIL basic_pop got=upd%b ccr%h tl%0d exp=upd1 ccrA5 tl0", upd, ccr_m, tl_of(1));
        end
        cycle();
        checks++;
        if (upd !== 1'b0 || ccr_m !== 8'hA5) begin
            failures++; $display("FAIL basic_hold got=upd%b ccr%h exp=upd0 ccrA5", upd, ccr_m);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_v [3];
        exp_v[0] = 8'h33; exp_v[1] = 8'h22; exp_v[2] = 8'h11;
        trap(2'd2, 8'h11);
        trap(2'd2, 8'h22);
        trap(2'd2, 8'h33);
        checks++;
        if (tl_of(2) !== 3'd3) begin
            failures++; $display("FAIL b2b_tl got=%0d exp=3", tl_of(2));
        end
        dr_vld = 1'b1; dr_tid = 2'd2;
        for (int i = 0; i < 3; i++) begin
            cycle();
            checks++;
            if (upd !== 1'b1 || ccr_m !== exp_v[i]) begin
                failures++;
                $display("FAIL b2b_pop%0d got=upd%b ccr%h exp=upd1 ccr%h", i, upd, ccr_m, exp_v[i]);
            end
        end
        dr_vld = 1'b0;
        cycle();
        checks++;
        if (upd !== 1'b0 || tl_of(2) !== 3'd0 || err_unf !== 4'h0) begin
            failures++;
            $display("FAIL b2b_end got=upd%b tl%0d unf%h exp=upd0 tl0 unf0", upd, tl_of(2), err_unf);
        end
    endtask

    task automatic test_overflow();
        for (int i = 1; i <= 7; i++) trap(2'd0, 8'h70 + 8'(i));
        checks++;
        if (tl_of(0) !== 3'd6 || err_ovf !== 4'b0001) begin
            failures++; $display("FAIL ovf_state got=tl%0d ovf%h exp=tl6 ovf1", tl_of(0), err_ovf);
        end
        dr_vld = 1'b1; dr_tid = 2'd0;
        cycle();
        checks++;
        if (upd !== 1'b1 || ccr_m !== 8'h77 || tl_of(0) !== 3'd5) begin
            failures++;
            $display("FAIL ovf_pop got=upd%b ccr%h tl%0d exp=upd1 ccr77 tl5", upd, ccr_m, tl_of(0));
        end
        // Level 5 still holds the fifth push
        cycle();
        checks++;
        if (ccr_m !== 8'h75) begin
            failures++; $display("FAIL ovf_below got=%h exp=75", ccr_m);
        end
        for (int i = 0; i < 4; i++) cycle();
        dr_vld = 1'b0;
        cycle();
        checks++;
        if (tl_of(0) !== 3'd0 || ccr_m !== 8'h71 || err_unf !== 4'h0) begin
            failures++;
            $display("FAIL ovf_drain got=tl%0d ccr%h unf%h exp=tl0 ccr71 unf0", tl_of(0), ccr_m, err_unf);
        end
    endtask

    task automatic test_underflow();
        dr_vld = 1'b1; dr_tid = 2'd3;
        cycle();
        dr_vld = 1'b0;
        checks++;
        if (upd !== 1'b0 || ccr_m !== 8'h71) begin
            failures++; $display("FAIL unf_out got=upd%b ccr%h exp=upd0 ccr71", upd, ccr_m);
        end
        cycle();
        checks++;
        if (err_unf !== 4'b1000 || err_ovf !== 4'b0001 || tl_thr !== 12'h000) begin
            failures++;
            $display("FAIL unf_flags got=unf%h ovf%h tl%h exp=unf8 ovf1 tl000", err_unf, err_ovf, tl_thr);
        end
    endtask

    task automatic test_conflict();
        trap(2'd0, 8'h10);
        // Same-thread trap and pop: trap wins, pop dropped silently
        ccr0 = 8'h5A;
        trap_vld = 1'b1; trap_tid = 2'd0;
        dr_vld = 1'b1; dr_tid = 2'd0;
        cycle();
        idle();
        checks++;
        if (upd !== 1'b0 || tl_of(0) !== 3'd2 || err_unf !== 4'b1000) begin
            failures++;
            $display("FAIL same_thr got=upd%b tl%0d unf%h exp=upd0 tl2 unf8", upd, tl_of(0), err_unf);
        end
        trap(2'd1, 8'hC3);
        // Different threads: both proceed
        ccr0 = 8'h66;
        trap_vld = 1'b1; trap_tid = 2'd0;
        dr_vld = 1'b1; dr_tid = 2'd1;
        cycle();
        idle();
        checks++;
        if (upd !== 1'b1 || ccr_m !== 8'hC3 || tl_of(0) !== 3'd3 || tl_of(1) !== 3'd0) begin
            failures++;
            $display("FAIL diff_thr got=upd%b ccr%h tl0=%0d tl1=%0d exp=upd1 ccrC3 tl0=3 tl1=0",
                     upd, ccr_m, tl_of(0), tl_of(1));
        end
        dr_vld = 1'b1; dr_tid = 2'd0;
        cycle();
        checks++;
        if (ccr_m !== 8'h66) begin
            failures++; $display("FAIL conf_pop3 got=%h exp=66", ccr_m);
        end
        cycle();
        checks++;
        if (ccr_m !== 8'h5A) begin
            failures++; $display("FAIL conf_pop2 got=%h exp=5A", ccr_m);
        end
        cycle();
        dr_vld = 1'b0;
        checks++;
        if (ccr_m !== 8'h10 || tl_of(0) !== 3'd0) begin
            failures++; $display("FAIL conf_pop1 got=ccr%h tl%0d exp=ccr10 tl0", ccr_m, tl_of(0));
        end
        cycle();
    endtask

`ifdef TLU_CCR_PARITY_EN
    task automatic test_parity();
        trap(2'd1, 8'h0F);
        dr_vld = 1'b1; dr_tid = 2'd1;
        cycle();
        dr_vld = 1'b0;
        checks++;
        if (upd !== 1'b1 || err_par !== 1'b0) begin
            failures++; $display("FAIL par_clean got=upd%b par%b exp=upd1 par0", upd, err_par);
        end
        trap(2'd1, 8'h0F);
        // Corrupt one data bit of level 1 (stored word {parity=1, 0x0F})
        force dut.g_thr[1].u_stack.mem_q[1] = 9'h10E;
        dr_vld = 1'b1; dr_tid = 2'd1;
        cycle();
        dr_vld = 1'b0;
        checks++;
        if (upd !== 1'b1 || err_par !== 1'b1 || ccr_m !== 8'h0E) begin
            failures++;
            $display("FAIL par_err got=upd%b par%b ccr%h exp=upd1 par1 ccr0E", upd, err_par, ccr_m);
        end
        release dut.g_thr[1].u_stack.mem_q[1];
        cycle();
        checks++;
        if (err_par !== 1'b0) begin
            failures++; $display("FAIL par_pulse got=%b exp=0", err_par);
        end
    endtask
`endif

    task automatic test_reset_mid_pop();
        trap(2'd2, 8'h99);
        dr_vld = 1'b1; dr_tid = 2'd2;
        cycle();
        dr_vld = 1'b0;
        checks++;
        if (upd !== 1'b1 || ccr_m !== 8'h99) begin
            failures++; $display("FAIL rst_pre got=upd%b ccr%h exp=upd1 ccr99", upd, ccr_m);
        end
        trap(2'd3, 8'h44);
        rst = 1'b1;
        #1;
        checks++;
        if (upd !== 1'b0 || tl_thr !== 12'h000 || err_ovf !== 4'h0 || err_unf !== 4'h0) begin
            failures++;
            $display("FAIL rst_async got=upd%b tl%h ovf%h unf%h exp=upd0 tl000 ovf0 unf0",
                     upd, tl_thr, err_ovf, err_unf);
        end
        cycle();
        rst = 1'b0;
        cycle();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_overflow();
        test_underflow();
        test_conflict();
`ifdef TLU_CCR_PARITY_EN
        test_parity();
`endif
        test_reset_mid_pop();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute time bound so the run always ends
    initial begin
        #100000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
